// File: rtl/mem_access_cycle_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_cycle_pkg
// Shared definitions for the memory-stage bus access logic:
//   - funct3 access-width encodings (B, H, W, BU, HU)
//   - memory-stage FSM state type
//   - default bus-abort timeout
//   - helper that flags misaligned effective addresses
// ---------------------------------------------------------------------------
package mem_access_cycle_pkg;

   // Access width encodings taken from InstrM[14:12]
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Default number of request cycles before a bus access is abandoned
   localparam int unsigned DEFAULT_TIMEOUT = 255;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } memState_t;

   // Halfwords need an even address, words need a 4-byte aligned address.
   // Unused encodings fall into the word case so they are checked strictly.
   function automatic logic isMisaligned(input logic [2:0] funct3,
                                         input logic [1:0] addrLow);
      logic mis;
      case (funct3)
         F3_B, F3_BU: mis = 1'b0;
         F3_H, F3_HU: mis = addrLow[0];
         default:     mis = (addrLow != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_cycle_lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the data memory port.
//   funct3     in  3   access width (InstrM[14:12])
//   addrLow    in  2   effective address bits [1:0]
//   storeData  in  32  register value to store
//   rdata      in  32  word returned by the bus
//   byteEn     out 4   byte enables for the addressed lanes
//   storeLanes out 32  store data replicated across lanes
//   loadData   out 32  selected and sign/zero-extended load value
//   misaligned out 1   access violates its natural alignment
// ---------------------------------------------------------------------------
module lsu_align
   import mem_access_cycle_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addrLow,
   input  logic [31:0] storeData,
   input  logic [31:0] rdata,
   output logic [3:0]  byteEn,
   output logic [31:0] storeLanes,
   output logic [31:0] loadData,
   output logic        misaligned
);

   logic [7:0]  byteLane_s;
   logic [15:0] halfLane_s;

   // Alignment check shared with the package helper
   always_comb begin
      misaligned = isMisaligned(funct3, addrLow);
   end

   // Store side: enables shift with the address, data is replicated so the
   // addressed lanes always carry the value regardless of offset
   always_comb begin
      byteEn     = 4'b1111;
      storeLanes = storeData;
      case (funct3)
         F3_B, F3_BU: begin
            byteEn     = 4'b0001 << addrLow;
            storeLanes = {4{storeData[7:0]}};
         end
         F3_H, F3_HU: begin
            byteEn     = 4'b0011 << addrLow;
            storeLanes = {2{storeData[15:0]}};
         end
         default: begin
            byteEn     = 4'b1111;
            storeLanes = storeData;
         end
      endcase
   end

   // Load side: pick the addressed byte and halfword lanes
   always_comb begin
      byteLane_s = rdata[7:0];
      case (addrLow)
         2'b00:   byteLane_s = rdata[7:0];
         2'b01:   byteLane_s = rdata[15:8];
         2'b10:   byteLane_s = rdata[23:16];
         2'b11:   byteLane_s = rdata[31:24];
         default: byteLane_s = rdata[7:0];
      endcase
      if (addrLow[1]) begin
         halfLane_s = rdata[31:16];
      end else begin
         halfLane_s = rdata[15:0];
      end
   end

   // Load side: extend the selected lane to a full register value
   always_comb begin
      loadData = rdata;
      case (funct3)
         F3_B:    loadData = {{24{byteLane_s[7]}}, byteLane_s};
         F3_BU:   loadData = {24'h000000, byteLane_s};
         F3_H:    loadData = {{16{halfLane_s[15]}}, halfLane_s};
         F3_HU:   loadData = {16'h0000, halfLane_s};
         default: loadData = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_cycle.sv
// ---------------------------------------------------------------------------
// mem_access_cycle
// Memory stage of the pipeline: drives the data bus for loads/stores, stalls
// the front of the pipeline while the bus is busy, aborts hung accesses and
// holds the MEM/WB pipeline register.
//   clk, rst                      clock, async active-low reset
//   RegWriteM..InstrM             EX/MEM register contents (ALU_ResultM is
//                                 the effective address)
//   dmem_req/we/addr/wdata/be     bus request side
//   dmem_ack/rdata                bus response side
//   stall_M                       freezes PC, IF/ID, ID/EX and EX/MEM
//   RegWriteW..InstrW             MEM/WB register contents
//   misalign_W, buserr_W          one-cycle exception flags in MEM/WB
// ---------------------------------------------------------------------------
module mem_access_cycle
   import mem_access_cycle_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        LoadM,
   input  logic        StoreM,
   input  logic [1:0]  ResultSrcM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] InstrM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_M,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] InstrW,
   output logic        misalign_W,
   output logic        buserr_W
);

   // The counter holds the number of request cycles already spent on the
   // current access (the IDLE launch cycle counts as the first), so the
   // access is abandoned on its TIMEOUT-th request cycle. The >= compare
   // only matters for TIMEOUT=1, where the first WAIT cycle already aborts.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

   memState_t   state_r;
   logic [7:0]  waitCount_r;

   logic        misaligned_s;
   logic [3:0]  byteEn_s;
   logic [31:0] storeLanes_s;
   logic [31:0] loadData_s;
   logic        memOp_s;
   logic        accessValid_s;
   logic        inWait_s;
   logic        timeout_s;
   logic        loadDone_s;

   lsu_align u_lsu_align (
      .funct3     (InstrM[14:12]),
      .addrLow    (ALU_ResultM[1:0]),
      .storeData  (WriteDataM),
      .rdata      (dmem_rdata),
      .byteEn     (byteEn_s),
      .storeLanes (storeLanes_s),
      .loadData   (loadData_s),
      .misaligned (misaligned_s)
   );

   // Access qualification, abort detection and the combinational bus/stall
   // outputs. Address, enables and data come straight from EX/MEM, which is
   // frozen by stall_M, so they stay stable for the whole request.
   always_comb begin
      memOp_s       = LoadM | StoreM;
      accessValid_s = memOp_s & ~misaligned_s;
      inWait_s      = (state_r == ST_WAIT);
      timeout_s     = inWait_s & (waitCount_r >= TIMEOUT_LAST) & ~dmem_ack;
      if (inWait_s) begin
         dmem_req = 1'b1;
      end else begin
         dmem_req = accessValid_s;
      end
      stall_M    = dmem_req & ~dmem_ack & ~timeout_s;
      dmem_we    = accessValid_s & StoreM;
      dmem_addr  = {ALU_ResultM[31:2], 2'b00};
      dmem_be    = byteEn_s;
      dmem_wdata = storeLanes_s;
      // A store wins when both LoadM and StoreM are set
      loadDone_s = accessValid_s & LoadM & ~StoreM & ~timeout_s;
   end

   // Bus access FSM and request-cycle counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         waitCount_r <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (dmem_req & ~dmem_ack) begin
                  state_r     <= ST_WAIT;
                  waitCount_r <= 8'd1;
               end else begin
                  state_r     <= ST_IDLE;
                  waitCount_r <= 8'd0;
               end
            end
            ST_WAIT: begin
               if (dmem_ack | timeout_s) begin
                  state_r     <= ST_IDLE;
                  waitCount_r <= 8'd0;
               end else begin
                  state_r     <= ST_WAIT;
                  waitCount_r <= waitCount_r + 8'd1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               waitCount_r <= 8'd0;
            end
         endcase
      end
   end

   // MEM/WB register: bubble while stalled, otherwise capture EX/MEM plus
   // the load result and the exception flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW   <= 1'b0;
         ResultSrcW  <= 2'b00;
         RD_W        <= 5'd0;
         PCPlus4W    <= 32'h00000000;
         ALU_ResultW <= 32'h00000000;
         ReadDataW   <= 32'h00000000;
         InstrW      <= 32'h00000000;
         misalign_W  <= 1'b0;
         buserr_W    <= 1'b0;
      end else if (stall_M) begin
         // Remaining fields keep their previous values
         RegWriteW   <= 1'b0;
         InstrW      <= 32'h00000000;
         misalign_W  <= 1'b0;
         buserr_W    <= 1'b0;
      end else begin
         RegWriteW   <= RegWriteM & ~(memOp_s & misaligned_s) & ~timeout_s;
         ResultSrcW  <= ResultSrcM;
         RD_W        <= RD_M;
         PCPlus4W    <= PCPlus4M;
         ALU_ResultW <= ALU_ResultM;
         ReadDataW   <= loadDone_s ? loadData_s : 32'h00000000;
         InstrW      <= InstrM;
         misalign_W  <= memOp_s & misaligned_s;
         buserr_W    <= timeout_s;
      end
   end

endmodule

// File: doc/mem_access_cycle.md
MEM_ACCESS_CYCLE -- requirements
Module: mem_access_cycle

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum WAIT cycles before a bus abort (range 1..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- RegWriteM, LoadM, StoreM  in  1 each  EX/MEM control.
- ResultSrcM  in  2  EX/MEM result select.
- RD_M  in  5  destination register.
- PCPlus4M, WriteDataM, ALU_ResultM, InstrM  in  32 each  EX/MEM data; ALU_ResultM is the effective address.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address; bits[1:0] are 0.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  bus completion.
- dmem_rdata  in  32  read word.
- stall_M  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- RegWriteW  out  1  MEM/WB register write.
- ResultSrcW  out  2  MEM/WB result select.
- RD_W  out  5  MEM/WB destination register.
- PCPlus4W, ALU_ResultW, ReadDataW, InstrW  out  32 each  MEM/WB data.
- misalign_W  out  1  1-cycle exception flag.
- buserr_W  out  1  1-cycle exception flag.

Function
REQ-003 The block SHALL take access width from InstrM[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
REQ-004 An access SHALL be misaligned when H/HU has addr[0]=1, or W has addr[1:0]≠00.
REQ-005 A valid access SHALL be (LoadM|StoreM) and not misaligned; LoadM and StoreM both set SHALL be treated as a store.
REQ-006 The FSM SHALL have states IDLE and WAIT.
REQ-007 In IDLE, dmem_req SHALL follow the valid access combinationally; in WAIT, dmem_req SHALL be 1.
REQ-008 The FSM SHALL move IDLE->WAIT on dmem_req & ~dmem_ack.
REQ-009 The FSM SHALL move WAIT->IDLE on dmem_ack or on timeout.
REQ-010 stall_M SHALL equal dmem_req & ~dmem_ack & ~timeout (combinational); a zero-wait ack SHALL produce no stall.
REQ-011 dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL stay stable while dmem_req=1, because EX/MEM is frozen by stall_M.
REQ-012 Store lanes SHALL be:
- B: be = 0001 << addr[1:0], data replicated into all 4 bytes.
- H: be = 0011 << addr[1:0], data replicated into both halves.
- W: be = 1111.
REQ-013 Load data SHALL select the byte/half lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-014 A wait counter SHALL be 8 bits, cleared in IDLE and incremented each WAIT cycle; timeout = (WAIT & count == TIMEOUT-1 & ~dmem_ack).
REQ-015 The MEM/WB register SHALL load every cycle from the EX/MEM inputs plus ReadDataW = the extended load data.
REQ-016 While stall_M=1, the MEM/WB register SHALL load a bubble: RegWriteW=0, InstrW=0, flags=0, other fields don't-care but held.
REQ-017 On a misaligned access: no request, no stall, RegWriteW=0, misalign_W=1 for one cycle; other fields SHALL still be captured.
REQ-018 On timeout: the FSM returns to IDLE, RegWriteW=0, buserr_W=1 for one cycle, ReadDataW=0.
REQ-019 A non-memory instruction SHALL pass to MEM/WB with 1-cycle latency and ReadDataW=0.
REQ-020 dmem_ack in IDLE without dmem_req SHALL be ignored.
REQ-021 dmem_ack and timeout in the same cycle cannot co-occur, because ack wins by the definition in REQ-014.

Reset
REQ-022 On rst=0 the FSM SHALL be IDLE, the counter 0, and all MEM/WB outputs, misalign_W and buserr_W 0.
REQ-023 On rst=0, dmem_req and stall_M SHALL evaluate to 0 while LoadM/StoreM are 0, since EX/MEM is also reset.
REQ-024 Reset asserted mid-WAIT SHALL abandon the access immediately; no completion and no exception flag SHALL follow deassertion.

Structure
REQ-025 The shared pipeline package SHALL hold the funct3 width encodings, the FSM state enum and the default TIMEOUT.
REQ-026 Lane steering and load extension SHALL live in one combinational sub-module, lsu_align, instantiated once; the FSM, counter and MEM/WB register SHALL stay in the top module.

Verification
REQ-027 LW, addr 0x100, ack in the same cycle -> dmem_be=1111, no stall, next cycle ReadDataW=rdata, RegWriteW=1.
REQ-028 LB, addr 0x103, rdata 0x80FFFFFF, ack after 3 cycles -> stall_M high 3 cycles, 3 bubbles, then ReadDataW=0xFFFFFF80.
REQ-029 SH, addr 0x202, WriteDataM 0x0000BEEF -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1, RegWriteW=0.
REQ-030 LW, addr 0x101 -> dmem_req=0, stall_M=0, misalign_W=1 for 1 cycle, RegWriteW=0.
REQ-031 LHU with ack never asserted, TIMEOUT=4 -> stall_M high 3 cycles, buserr_W=1 once, FSM back in IDLE.
REQ-032 rst=0 asserted during WAIT, then released -> all outputs 0, dmem_req=0, no flag pulses.
